// File: rtl/add_seq.sv
`default_nettype none
// ============================================================================
// Module   : add_seq
// Brief    : Multi-cycle adder/subtractor, CHUNK bits per clock, valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module add_seq #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int NCH   = WIDTH / CHUNK;
  localparam int CNT_W = (NCH > 1) ? $clog2(NCH) : 1;

  generate
    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
      $error("add_seq: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Operands and result viewed as NCH chunks so the counter indexes them directly
  logic [NCH-1:0][CHUNK-1:0] r_a;
  logic [NCH-1:0][CHUNK-1:0] r_b;
  logic [NCH-1:0][CHUNK-1:0] r_sum;
  logic [NCH-1:0][CHUNK-1:0] w_sum_next;
  logic [CNT_W-1:0]          r_cnt;
  logic                      r_carry;
  logic                      r_a_msb;
  logic                      r_b_msb;
  logic                      r_cout;
  logic                      r_ovf;
  logic                      r_zero;
  logic [CHUNK-1:0]          w_s;
  logic                      w_c;
  logic                      w_last;
  logic [WIDTH-1:0]          w_b_eff;

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign w_last    = (r_cnt == CNT_W'(NCH - 1));
  assign w_b_eff   = sub ? ~b : b;

  assign {w_c, w_s} = {1'b0, r_a[r_cnt]} + {1'b0, r_b[r_cnt]} + {{CHUNK{1'b0}}, r_carry};

  always_comb begin
    w_sum_next        = r_sum;
    w_sum_next[r_cnt] = w_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (clr) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (in_valid)  w_state_next = RUN;
        RUN:     if (w_last)    w_state_next = DONE;
        DONE:    if (out_ready) w_state_next = IDLE;
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else if (clr) begin
      r_cnt   <= '0;
      r_carry <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= w_b_eff;
            r_carry <= cin ^ sub;
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= w_b_eff[WIDTH-1];
            r_cnt   <= '0;
          end
        end
        RUN: begin
          r_sum   <= w_sum_next;
          r_carry <= w_c;
          if (w_last) begin
            r_cnt  <= '0;
            r_cout <= w_c;
            r_ovf  <= (r_a_msb == r_b_msb) & (w_s[CHUNK-1] != r_a_msb);
            r_zero <= (w_sum_next == '0);
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign sum      = r_sum;
  assign cout     = r_cout;
  assign overflow = r_ovf;
  assign zero     = r_zero;

endmodule
`default_nettype wire
